// File: rtl/fp_fadd_fsub_core.sv
// fp_fadd_fsub_core
// -----------------------------------------------------------------------------
// IEEE-754 binary32 adder/subtractor for the FADD/FSUB reservation station.
// Rounding is round-to-nearest-even. Denormal inputs and tiny results are
// flushed to zero, and every NaN result is the canonical quiet NaN 0x7FC00000.
//
// Ports:
//   aclk                    clock, used only by the optional output register
//   reset                   synchronous active-high reset of that register
//   s_axis_a_tdata [31:0]   operand A
//   s_axis_b_tdata [31:0]   operand B
//   s_axis_operation_tdata  0 = A+B, 1 = A-B
//   m_axis_result_tdata     binary32 result
//
// Configuration macro: FADD_FSUB_OUTPUT_REG_EN
//   undefined : the result is combinational and appears in the same cycle as
//               the operands (latency 0).
//   defined   : one output register is added (latency 1, throughput 1 per
//               cycle). Reset clears it to 0x00000000.
//
// Handshake: there is no valid/ready. The core computes on every cycle, and
// the caller decides which cycle's result it consumes.
// -----------------------------------------------------------------------------
module fp_fadd_fsub_core (
  input  logic        aclk,
  input  logic        reset,
  input  logic [31:0] s_axis_a_tdata,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_operation_tdata,
  output logic [31:0] m_axis_result_tdata
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Field unpack. Subtraction is an add with B's sign flipped.
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] man_a, man_b;
  assign sign_a = s_axis_a_tdata[31];
  assign sign_b = s_axis_b_tdata[31] ^ s_axis_operation_tdata;
  assign exp_a  = s_axis_a_tdata[30:23];
  assign exp_b  = s_axis_b_tdata[30:23];
  assign man_a  = s_axis_a_tdata[22:0];
  assign man_b  = s_axis_b_tdata[22:0];

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (exp_a == 8'd0);  // exp=0 (including denormals) counts as zero
  assign b_zero = (exp_b == 8'd0);
  assign a_inf  = (exp_a == 8'hFF) && (man_a == 23'd0);
  assign b_inf  = (exp_b == 8'hFF) && (man_b == 23'd0);
  assign a_nan  = (exp_a == 8'hFF) && (man_a != 23'd0);
  assign b_nan  = (exp_b == 8'hFF) && (man_b != 23'd0);

  // Swap so that the operand with the larger magnitude is called "l".
  logic        b_larger;
  logic        sign_l, sign_s;
  logic [7:0]  exp_l, exp_s;
  logic [22:0] man_l, man_s;
  assign b_larger = ({exp_b, man_b} > {exp_a, man_a});
  assign sign_l   = b_larger ? sign_b : sign_a;
  assign sign_s   = b_larger ? sign_a : sign_b;
  assign exp_l    = b_larger ? exp_b  : exp_a;
  assign exp_s    = b_larger ? exp_a  : exp_b;
  assign man_l    = b_larger ? man_b  : man_a;
  assign man_s    = b_larger ? man_a  : man_b;

  // Each significand is {hidden, 23 fraction, guard, round, sticky}.
  logic [26:0] ext_l, ext_s;
  assign ext_l = {1'b1, man_l, 3'b000};
  assign ext_s = {1'b1, man_s, 3'b000};

  // Align the smaller operand. A shift of 27 or more leaves only the sticky
  // bit, so the shift amount is clamped there. The lower half of the
  // double-width shift holds the bits that were shifted out.
  logic [7:0]  exp_diff;
  logic [4:0]  shamt;
  logic [53:0] align_full;
  logic [26:0] aligned_s;
  assign exp_diff   = exp_l - exp_s;
  assign shamt      = (exp_diff > 8'd26) ? 5'd27 : exp_diff[4:0];
  assign align_full = {ext_s, 27'd0} >> shamt;
  assign aligned_s  = {align_full[53:28], align_full[27] | (|align_full[26:0])};

  logic        eff_sub;
  logic [27:0] sum;
  assign eff_sub = sign_l ^ sign_s;
  assign sum     = eff_sub ? ({1'b0, ext_l} - {1'b0, aligned_s})
                           : ({1'b0, ext_l} + {1'b0, aligned_s});

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Normalize the sum. On a carry-out, shift right by one and keep the
  // dropped bit in sticky. After cancellation, shift left by the
  // leading-zero count.
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_norm;
  always_comb begin
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm     = {sum[27:2], sum[1] | sum[0]};
      exp_norm = $signed({2'b00, exp_l}) + 10'sd1;
    end else begin
      norm     = sum[26:0] << lz;
      exp_norm = $signed({2'b00, exp_l}) - $signed({5'd0, lz});
    end
  end

  // Round to nearest, ties to even.
  logic [23:0]       sig_pre;
  logic              round_up;
  logic [24:0]       sig_rnd;
  logic [22:0]       man_res;
  logic signed [9:0] exp_res;
  assign sig_pre  = norm[26:3];
  assign round_up = norm[2] & (norm[1] | norm[0] | sig_pre[0]);
  assign sig_rnd  = {1'b0, sig_pre} + 25'(round_up);

  always_comb begin
    if (sig_rnd[24]) begin
      // Rounding carried out to 10.000...: renormalize.
      man_res = sig_rnd[23:1];
      exp_res = exp_norm + 10'sd1;
    end else begin
      man_res = sig_rnd[22:0];
      exp_res = exp_norm;
    end
  end

  logic [31:0] result_comb;
  always_comb begin
    result_comb = 32'd0;
    if (a_nan || b_nan) begin
      result_comb = QNAN;
    end else if (a_inf && b_inf) begin
      result_comb = (sign_a != sign_b) ? QNAN : {sign_a, 8'hFF, 23'd0};
    end else if (a_inf) begin
      result_comb = {sign_a, 8'hFF, 23'd0};
    end else if (b_inf) begin
      result_comb = {sign_b, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      // The result is -0 only when both zeros are negative.
      result_comb = {sign_a & sign_b, 31'd0};
    end else if (a_zero) begin
      result_comb = {sign_b, exp_b, man_b};
    end else if (b_zero) begin
      result_comb = {sign_a, exp_a, man_a};
    end else if (sum == 28'd0) begin
      result_comb = 32'd0;  // exact cancellation gives +0
    end else if (exp_res >= 10'sd255) begin
      result_comb = {sign_l, 8'hFF, 23'd0};
    end else if (exp_res <= 10'sd0) begin
      result_comb = {sign_l, 31'd0};  // flushed to zero
    end else begin
      result_comb = {sign_l, exp_res[7:0], man_res};
    end
  end

`ifdef FADD_FSUB_OUTPUT_REG_EN
  logic [31:0] result_q;
  always_ff @(posedge aclk) begin
    if (reset) result_q <= 32'd0;
    else       result_q <= result_comb;
  end
  assign m_axis_result_tdata = result_q;
`else
  // The clock and reset only feed the optional register.
  logic unused_clk_rst;
  assign unused_clk_rst = aclk ^ reset;
  assign m_axis_result_tdata = result_comb;
`endif

endmodule

// File: tb/tb_fp_fadd_fsub_core.sv
// tb_fp_fadd_fsub_core
// -----------------------------------------------------------------------------
// Bench for fp_fadd_fsub_core. It works in both builds: the result-wait task
// follows the FADD_FSUB_OUTPUT_REG_EN macro (0 or 1 cycle latency).
// Expected values come either from directed tables or from an exact
// integer-to-binary32 model for small integer operands.
// -----------------------------------------------------------------------------
module tb_fp_fadd_fsub_core;

  // Clock and reset.
  logic        aclk = 1'b0;
  logic        reset;
  logic [31:0] a_data, b_data, result;
  logic        op;

  always #5 aclk = ~aclk;

  fp_fadd_fsub_core dut (
    .aclk                   (aclk),
    .reset                  (reset),
    .s_axis_a_tdata         (a_data),
    .s_axis_b_tdata         (b_data),
    .s_axis_operation_tdata (op),
    .m_axis_result_tdata    (result)
  );

  // Scoreboard.
  logic [31:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
  } vec_t;

  // Driver tasks.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] exp);
    @(negedge aclk);
    a_data = a;
    b_data = b;
    op     = o;
    exp_q.push_back(exp);
  endtask

  task automatic wait_result;
`ifdef FADD_FSUB_OUTPUT_REG_EN
    @(posedge aclk);
    #1;
`else
    #1;
`endif
  endtask

  // Exact conversion of a small integer (|n| < 2^24) to binary32.
  function automatic logic [31:0] int_to_f32(input int n);
    logic        s;
    int          mag;
    int          p;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    s   = (n < 0);
    mag = s ? -n : n;
    p   = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    m = 32'(mag) << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  task automatic test_reset;
    logic [31:0] got, exp;
    reset = 1'b1;
`ifdef FADD_FSUB_OUTPUT_REG_EN
    drive(32'h3F800000, 32'h40000000, 1'b0, 32'h00000000);
`else
    drive(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
`endif
    wait_result;
    got = result;
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL reset got=%h exp=%h", got, exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith;
    vec_t v[11];
    logic [31:0] got, exp;
    v = '{
      '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000},
      '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000},
      '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000},
      '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000},
      '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000},
      '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000},
      '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000},
      '{32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000},
      '{32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000}
    };
    for (int i = 0; i < 11; i++) begin
      drive(v[i].a, v[i].b, v[i].op, v[i].r);
      wait_result;
      got = result;
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL arith[%0d] a=%h b=%h op=%0d got=%h exp=%h",
                 i, v[i].a, v[i].b, v[i].op, got, exp);
      end
    end
  endtask

  task automatic test_rounding;
    vec_t v[6];
    logic [31:0] got, exp;
    v = '{
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000},
      '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002},
      '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000},
      '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001},
      '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF}
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].a, v[i].b, v[i].op, v[i].r);
      wait_result;
      got = result;
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL round[%0d] a=%h b=%h op=%0d got=%h exp=%h",
                 i, v[i].a, v[i].b, v[i].op, got, exp);
      end
    end
  endtask

  task automatic test_specials;
    vec_t v[10];
    logic [31:0] got, exp;
    v = '{
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000},
      '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000},
      '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000},
      '{32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000},
      '{32'h3F800000, 32'hFFC00001, 1'b1, 32'h7FC00000},
      '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000},
      '{32'hFF800000, 32'h42000000, 1'b0, 32'hFF800000},
      '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000}
    };
    for (int i = 0; i < 10; i++) begin
      drive(v[i].a, v[i].b, v[i].op, v[i].r);
      wait_result;
      got = result;
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL special[%0d] a=%h b=%h op=%0d got=%h exp=%h",
                 i, v[i].a, v[i].b, v[i].op, got, exp);
      end
    end
  endtask

  // Random stream of small integer operands, one per cycle. Their sums and
  // differences are exact in binary32.
  task automatic test_back_to_back;
    int          x, y, r;
    logic        o;
    logic [31:0] fa, fb, got, exp;
    for (int i = 0; i < 40; i++) begin
      x  = int'($urandom_range(0, 8192)) - 4096;
      y  = int'($urandom_range(0, 8192)) - 4096;
      o  = 1'($urandom_range(0, 1));
      r  = o ? (x - y) : (x + y);
      fa = int_to_f32(x);
      fb = int_to_f32(y);
      drive(fa, fb, o, int_to_f32(r));
      wait_result;
      got = result;
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL stream[%0d] a=%h b=%h op=%0d got=%h exp=%h",
                 i, fa, fb, o, got, exp);
      end
    end
  endtask

`ifdef FADD_FSUB_OUTPUT_REG_EN
  // Reset asserted while an operation is in flight drops that result.
  task automatic test_reset_midstream;
    logic [31:0] got, exp;
    drive(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    wait_result;
    got = result;
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL midreset_pre got=%h exp=%h", got, exp);
    end
    drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000);
    reset = 1'b1;
    wait_result;
    got = result;
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL midreset got=%h exp=%h", got, exp);
    end
    reset = 1'b0;
    drive(32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
    wait_result;
    got = result;
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL midreset_post got=%h exp=%h", got, exp);
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    a_data = 32'd0;
    b_data = 32'd0;
    op     = 1'b0;
    repeat (2) @(posedge aclk);
    test_reset;
    test_arith;
    test_rounding;
    test_specials;
    test_back_to_back;
`ifdef FADD_FSUB_OUTPUT_REG_EN
    test_reset_midstream;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
